// File: rtl/mac_feeder_pkg.sv
// mac_feeder_pkg: shared defaults, FSM encoding and vector type for the MAC operand feeder
package mac_feeder_pkg;
  localparam int LANES_DEF = 3;
  localparam int DW_DEF = 8;
  localparam int DEPTH_DEF = 16;
  localparam int ACCW_DEF = 20;
  localparam int MAC_LAT_DEF = 1;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
  typedef logic [LANES_DEF*DW_DEF-1:0] vector_t;
endpackage

// File: rtl/feeder_vec_buf.sv
// feeder_vec_buf: single-write, single-read vector RAM whose read register is zero when no read is issued
module feeder_vec_buf
  import mac_feeder_pkg::*;
#(
  parameter int W = LANES_DEF*DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_data
);
  logic [W-1:0] mem [DEPTH];
  // storage is not reset; a same-cycle read of the written slot sees the old data
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  // read register is the operand output itself, forced to zero between reads
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_data <= '0;
    else rd_data <= rd_en ? mem[rd_addr] : '0;
endmodule

// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: streams buffered vectors onto the MAC operand bus and returns index-tagged acc results
// Optional feature macro FEEDER_MAX_TRACK_EN: adds max_data/max_idx tracking of the largest result per run
module mac_operand_feeder
  import mac_feeder_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DW = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ACCW = ACCW_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [LANES*DW-1:0]      wr_data,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   num_vec,
  output logic                     busy,
  output logic                     done,
  output logic [LANES*DW-1:0]      inputattr,
  output logic [LANES*DW-1:0]      inputcoeff,
  output logic                     op_valid,
  input  logic [ACCW-1:0]          acc,
  output logic                     res_valid,
  output logic [ACCW-1:0]          res_data,
  output logic [$clog2(DEPTH)-1:0] res_idx
`ifdef FEEDER_MAX_TRACK_EN
  ,
  output logic [ACCW-1:0]          max_data,
  output logic [$clog2(DEPTH)-1:0] max_idx
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] NMAX = CW'(DEPTH);
  state_t state, state_nx;
  logic [CW-1:0] cnt, n_lat;
  logic rd_en, take, in_flight;
  logic [AW-1:0] rd_addr, op_idx;
  logic [MAC_LAT-1:0] tag_v;
  logic [MAC_LAT-1:0][AW-1:0] tag_idx;
  assign take = (state == IDLE) && start;
  assign in_flight = op_valid | (|tag_v);
  feeder_vec_buf #(.W(LANES*DW), .DEPTH(DEPTH)) u_attr (
    .clk(clk), .rst(rst), .wr_en(wr_en & ~wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(inputattr)
  );
  feeder_vec_buf #(.W(LANES*DW), .DEPTH(DEPTH)) u_coeff (
    .clk(clk), .rst(rst), .wr_en(wr_en & wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(inputcoeff)
  );
  // run state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // run sequencing: stream N vectors, wait for the tag pipe to empty, pulse done
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !start ? IDLE : (num_vec == '0) ? DONE : STREAM;
      STREAM:  state_nx = (cnt < n_lat) ? STREAM : DRAIN;
      DRAIN:   state_nx = in_flight ? DRAIN : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // status and buffer read control; the first read is launched from IDLE so slot 0 lands on the first STREAM cycle
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    rd_en = (take && num_vec != '0) || (state == STREAM && cnt < n_lat);
    rd_addr = (state == IDLE) ? '0 : cnt[AW-1:0];
  end
  // run length latch (clamped to the buffer depth) and issue counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      n_lat <= '0;
    end else if (take) begin
      cnt <= CW'(1);
      n_lat <= (num_vec > NMAX) ? NMAX : num_vec;
    end else if (rd_en) cnt <= cnt + 1'b1;
  // operand valid and index registered alongside the buffer read data
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_valid <= 1'b0;
      op_idx <= '0;
    end else begin
      op_valid <= rd_en;
      op_idx <= rd_addr;
    end
  // tag pipe matching the MAC latency
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tag_v <= '0;
      tag_idx <= '0;
    end else begin
      tag_v[0] <= op_valid;
      tag_idx[0] <= op_idx;
      for (int i = 1; i < MAC_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  // capture acc when its tag emerges
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      res_valid <= 1'b0;
      res_data <= '0;
      res_idx <= '0;
    end else begin
      res_valid <= tag_v[MAC_LAT-1];
      if (tag_v[MAC_LAT-1]) begin
        res_data <= acc;
        res_idx <= tag_idx[MAC_LAT-1];
      end
    end
`ifdef FEEDER_MAX_TRACK_EN
  // running maximum per run; strict compare keeps the earliest index on ties
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      max_data <= '0;
      max_idx <= '0;
    end else if (take) begin
      max_data <= '0;
      max_idx <= '0;
    end else if (res_valid && res_data > max_data) begin
      max_data <= res_data;
      max_idx <= res_idx;
    end
`endif
endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb_mac_operand_feeder: scoreboard bench for the feeder with a registered dot-product MAC model
module tb_mac_operand_feeder;
  import mac_feeder_pkg::*;
  localparam int AW = 4;
  localparam int CW = 5;
  typedef struct packed {vector_t a; vector_t c;} op_t;
  typedef struct packed {logic [19:0] d; logic [3:0] i;} res_t;
  logic clk = 0, rst = 1, wr_en = 0, wr_sel = 0, start = 0;
  logic [AW-1:0] wr_addr = '0;
  vector_t wr_data = '0;
  logic [CW-1:0] num_vec = '0;
  logic busy, done, op_valid, res_valid;
  vector_t inputattr, inputcoeff;
  logic [19:0] acc = '0, res_data;
  logic [AW-1:0] res_idx;
`ifdef FEEDER_MAX_TRACK_EN
  logic [19:0] max_data;
  logic [AW-1:0] max_idx;
`endif
  int checks = 0, errors = 0;
  int ops_seen = 0, op_bursts = 0, res_seen = 0, res_bursts = 0, done_seen = 0;
  logic op_prev = 0, res_prev = 0;
  op_t op_q[$];
  res_t res_q[$];
  vector_t tab_a[16], tab_c[16];
  logic [19:0] tab_r[16];

  mac_operand_feeder #(.LANES(3), .DW(8), .DEPTH(16), .ACCW(20), .MAC_LAT(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .num_vec(num_vec), .busy(busy), .done(done),
    .inputattr(inputattr), .inputcoeff(inputcoeff), .op_valid(op_valid), .acc(acc),
    .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx)
`ifdef FEEDER_MAX_TRACK_EN
    , .max_data(max_data), .max_idx(max_idx)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] dot(input vector_t a, input vector_t c);
    logic [19:0] s = '0;
    for (int l = 0; l < 3; l++) s += 20'(a[8*l+:8]) * 20'(c[8*l+:8]);
    return s;
  endfunction

  always @(posedge clk) acc <= dot(inputattr, inputcoeff);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (op_valid) begin : mon_op
        op_t e;
        if (op_q.size() == 0) check("op_unexpected", 1, 0);
        else begin
          e = op_q.pop_front();
          check("inputattr", inputattr, e.a);
          check("inputcoeff", inputcoeff, e.c);
        end
        ops_seen++;
        if (!op_prev) op_bursts++;
      end
      if (res_valid) begin : mon_res
        res_t e;
        if (res_q.size() == 0) check("res_unexpected", 1, 0);
        else begin
          e = res_q.pop_front();
          check("res_data", res_data, e.d);
          check("res_idx", res_idx, e.i);
        end
        res_seen++;
        if (!res_prev) res_bursts++;
      end
      if (done) done_seen++;
    end
    op_prev = op_valid;
    res_prev = res_valid;
  end

  task automatic push(input int k);
    op_q.push_back({tab_a[k], tab_c[k]});
    res_q.push_back({tab_r[k], 4'(k)});
  endtask

  task automatic wr(input logic sel, input int addr, input vector_t data);
    wr_en = 1; wr_sel = sel; wr_addr = 4'(addr); wr_data = data;
    @(posedge clk); #1;
    wr_en = 0;
  endtask

  task automatic run(input int n, input int poke);
    int ob = ops_seen, obb = op_bursts, rs = res_seen, rbb = res_bursts, lat, ne;
    ne = n > 16 ? 16 : n;
    for (int k = 0; k < ne; k++) push(k);
    start = 1; num_vec = CW'(n);
    @(posedge clk); #1;
    start = 0;
    for (lat = 1; lat <= 100; lat++) begin
      @(negedge clk); #1;
      if (lat == poke) begin start = 1; num_vec = 5'd3; end
      if (lat == poke + 1) start = 0;
      if (done) break;
    end
    check("done_reached", done, 1);
    if (n == 0) check("done_latency", lat, 1);
    check("op_count", ops_seen - ob, ne);
    check("op_bursts", op_bursts - obb, ne > 0 ? 1 : 0);
    check("res_count", res_seen - rs, ne);
    check("res_bursts", res_bursts - rbb, ne > 0 ? 1 : 0);
    check("op_q_empty", op_q.size(), 0);
    check("res_q_empty", res_q.size(), 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ob, d0;
    tab_a[0] = 24'h311E0E; tab_c[0] = 24'h0A0000; tab_r[0] = 20'd490;
    tab_a[1] = 24'h2F200D; tab_c[1] = 24'h0A0000; tab_r[1] = 20'd470;
    for (int k = 2; k < 16; k++) begin
      tab_a[k] = {8'(k), 8'd1, 8'd2};
      tab_c[k] = 24'h030001;
      tab_r[k] = 20'(3 * k + 2);
    end
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_op_valid", op_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_inputattr", inputattr, 0);
    check("rst_inputcoeff", inputcoeff, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_idx", res_idx, 0);
    @(posedge clk); #1;
    rst = 0;
    wr(0, 0, tab_a[0]); wr(1, 0, tab_c[0]);
    run(1, 0);
    wr(0, 1, tab_a[1]); wr(1, 1, tab_c[1]);
    run(2, 0);
    run(0, 0);
    for (int k = 2; k < 16; k++) begin
      wr(0, k, tab_a[k]);
      wr(1, k, tab_c[k]);
    end
    run(20, 5);
    ob = ops_seen;
    for (int k = 0; k < 8; k++) push(k);
    start = 1; num_vec = 5'd8;
    @(posedge clk); #1;
    start = 0;
    for (int t = 0; t < 20 && ops_seen < ob + 3; t++) begin
      @(negedge clk); #1;
    end
    check("abort_at_op3", ops_seen - ob, 3);
    rst = 1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_op_valid", op_valid, 0);
    check("abort_inputattr", inputattr, 0);
    check("abort_inputcoeff", inputcoeff, 0);
    check("abort_res_valid", res_valid, 0);
    check("abort_done", done, 0);
    op_q.delete();
    res_q.delete();
    d0 = done_seen;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (10) @(posedge clk);
    #1;
    check("no_done_after_abort", done_seen - d0, 0);
    run(2, 0);
    tab_a[2] = 24'h311E0E; tab_c[2] = 24'h0A0000; tab_r[2] = 20'd490;
    wr(0, 2, tab_a[2]); wr(1, 2, tab_c[2]);
    run(3, 0);
`ifdef FEEDER_MAX_TRACK_EN
    check("max_data", max_data, 490);
    check("max_idx", max_idx, 0);
    repeat (3) @(posedge clk);
    #1;
    check("max_data_stable", max_data, 490);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_operand_feeder.md
Name: mac_operand_feeder

Overview:
- Buffers attribute and coefficient vectors and streams them, one per cycle, onto the packed operand bus of the mac1 datapath (inputattr/inputcoeff).
- Captures the MAC's acc output after a fixed latency and returns each result tagged with its vector index.
- Sits between the host/config writer and mac1; it drives the MAC's inputs and reads its output.

Parameters:
- LANES, 3, attribute/coefficient lanes per vector
- DW, 8, bits per lane (unsigned)
- DEPTH, 16, vector slots per buffer (power of 2)
- ACCW, 20, MAC accumulator width
- MAC_LAT, 1, cycles from operand presentation to valid acc (1..4)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  buffer write strobe
- wr_sel  in  1  0 = attribute buffer, 1 = coefficient buffer
- wr_addr  in  $clog2(DEPTH)  slot index
- wr_data  in  LANES*DW  packed vector, lane 2 in MSBs
- start  in  1  one-cycle run request
- num_vec  in  $clog2(DEPTH)+1  vectors to stream
- busy  out  1  run in progress
- done  out  1  one-cycle end-of-run pulse
- inputattr  out  LANES*DW  attribute operand to MAC
- inputcoeff  out  LANES*DW  coefficient operand to MAC
- op_valid  out  1  operands valid this cycle
- acc  in  ACCW  MAC result
- res_valid  out  1  res_data/res_idx valid
- res_data  out  ACCW  captured acc
- res_idx  out  $clog2(DEPTH)  vector index of result

Behaviour:
- Reset (async, active-high): all outputs 0, FSM to IDLE, pipeline tags cleared. Buffer contents are not reset.
- FSM states and transitions:
  - IDLE -> STREAM on start with num_vec>0.
  - IDLE -> DONE on start with num_vec==0.
  - STREAM -> DRAIN after the last vector is issued.
  - DRAIN -> DONE when no tags are in flight.
  - DONE -> IDLE after one cycle.
- busy = (state != IDLE). done is high only in DONE.
- start while busy: ignored.
- num_vec > DEPTH: clamped to DEPTH at latch time.
- num_vec and start are sampled only in IDLE.
- STREAM:
  - Registered outputs; on cycle k after entry, inputattr=attr[k], inputcoeff=coeff[k], op_valid=1, for k=0..N-1.
  - No gaps.
  - Outside STREAM: op_valid=0 and inputattr=inputcoeff=0, so the MAC sees zero contribution.
- Result pipe:
  - A MAC_LAT-deep shift register carries {valid, idx} alongside the operands.
  - When the tag emerges, res_data<=acc, res_idx<=idx, res_valid=1 for one cycle.
  - First result appears MAC_LAT+1 cycles after the first op_valid (one output register stage).
- Buffer writes:
  - Accepted in any state, taking effect next cycle.
  - A write to a slot in the same cycle it is read returns the old data.
  - Writes while busy are allowed but are the user's hazard.
- Arithmetic: no arithmetic on data; acc is passed through unchanged. Index counter width is $clog2(DEPTH)+1, with no wrap inside a run.
- Reset mid-run: run aborted, no done pulse, in-flight results discarded.

Optional Feature:
- Macro: FEEDER_MAX_TRACK_EN.
- Defined:
  - Adds outputs max_data[ACCW] and max_idx[$clog2(DEPTH)].
  - Both clear to 0 on start.
  - Updated on each res_valid where res_data > max_data (unsigned, strict, so the first-seen index wins ties).
  - Stable from done until the next start.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package mac_feeder_pkg:
  - LANES/DW/ACCW defaults
  - FSM state enum {IDLE, STREAM, DRAIN, DONE}
  - vector_t packed type
- One sub-module, feeder_vec_buf: a single-write, single-read synchronous vector RAM, instantiated twice (attribute and coefficient).

Test Plan:
- Single vector: write attr[0]={49,30,14}, coeff[0]={10,0,0}, start with num_vec=1. Expect inputattr=0x311E0E, inputcoeff=0x0A0000 for one cycle. With a registered dot-product MAC model (MAC_LAT=1), expect res_data=490, res_idx=0, then done.
- Two vectors back-to-back: slot 1 = {47,32,13}/{10,0,0}, num_vec=2. Expect op_valid high for 2 consecutive cycles and results 490 (idx 0) then 470 (idx 1) on consecutive cycles.
- num_vec=0: expect done one cycle after start, with op_valid and res_valid never asserted.
- num_vec=20 with DEPTH=16: expect exactly 16 op_valid cycles and 16 results, idx 0..15. A start issued while busy has no effect.
- Reset asserted mid-STREAM (cycle 3 of 8): outputs drop to 0 asynchronously, no done pulse. A following run with num_vec=2 behaves normally.
- With FEEDER_MAX_TRACK_EN: results 490, 470, 490 give max_data=490, max_idx=0.
